// File: rtl/alu_serial_exec.sv
// Digit-serial ALU execute stage: one operation at a time, DIGIT result bits per
// RUN cycle (LSB first), result and flags returned over a valid/ready handshake.
module alu_serial_exec #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Illegal
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [WIDTH-DIGIT-1:0] r_sh;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_illegal;

    logic [DIGIT-1:0]   w_a_dig;
    logic [DIGIT-1:0]   w_b_eff;
    logic [DIGIT:0]     w_sum;
    logic [DIGIT-1:0]   w_dig;
    logic [WIDTH-1:0]   w_sh_nxt;
    logic               w_sub;
    logic               w_legal;
    logic               w_lt;
    logic [WIDTH-1:0]   w_final;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == CNT_W'(N - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // One digit of the operation; sub/slt add the inverted B with the carry seeded to 1
    assign w_sub    = (r_op == OP_SUB) || (r_op == OP_SLT);
    assign w_a_dig  = r_a[DIGIT-1:0];
    assign w_b_eff  = w_sub ? ~r_b[DIGIT-1:0] : r_b[DIGIT-1:0];
    assign w_sum    = {1'b0, w_a_dig} + {1'b0, w_b_eff} + (DIGIT + 1)'(r_carry);
    assign w_legal  = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_AND)
                   || (r_op == OP_OR)  || (r_op == OP_SLT);

    always_comb begin
        w_dig = w_sum[DIGIT-1:0];
        case (r_op)
            OP_AND:  w_dig = w_a_dig & r_b[DIGIT-1:0];
            OP_OR:   w_dig = w_a_dig | r_b[DIGIT-1:0];
            default: w_dig = w_sum[DIGIT-1:0];
        endcase
    end

    assign w_sh_nxt = {w_dig, r_sh};
    // Differing signs decide slt directly, so a wrapped difference cannot mislead it
    assign w_lt     = (r_a_msb != r_b_msb) ? r_a_msb : w_dig[DIGIT-1];

    always_comb begin
        w_final = w_sh_nxt;
        if (!w_legal) begin
            w_final = '0;
        end else if (r_op == OP_SLT) begin
            w_final = WIDTH'(w_lt);
        end
    end

    // Operand capture, digit datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_sh        <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_a     <= SrcA;
                r_b     <= SrcB;
                r_op    <= ALUControl;
                r_cnt   <= '0;
                r_carry <= (ALUControl == OP_SUB) || (ALUControl == OP_SLT);
                r_a_msb <= SrcA[WIDTH-1];
                r_b_msb <= SrcB[WIDTH-1];
            end else if (r_state == RUN) begin
                r_a     <= r_a >> DIGIT;
                r_b     <= r_b >> DIGIT;
                r_cnt   <= r_cnt + CNT_W'(1);
                r_carry <= w_last ? 1'b0 : w_sum[DIGIT];
                r_sh    <= w_sh_nxt[WIDTH-1:DIGIT];
                if (w_last) begin
                    r_result  <= w_final;
                    r_zero    <= (w_final == '0);
                    r_illegal <= !w_legal;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign ALUResult = r_result;
    assign Zero      = r_zero;
    assign Illegal   = r_illegal;

endmodule

// File: tb/tb_alu_serial_exec.sv
// Directed bench for alu_serial_exec: expected results queued at issue, checked on out_valid.
module tb_alu_serial_exec;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Illegal;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_serial_exec #(.WIDTH(32), .DIGIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.ill = 1'b0;
        case (op)
            OP_ADD:  e.res = a + b;
            OP_SUB:  e.res = a - b;
            OP_AND:  e.res = a & b;
            OP_OR:   e.res = a | b;
            OP_SLT:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin
                e.res = 32'd0;
                e.ill = 1'b1;
            end
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Drive a request at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        q.push_back(model(op, a, b));
        while (in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("in_ready before issue", 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        @(negedge clk);
        in_valid   = 1'b0;
        SrcA       = ~a;
        SrcB       = ~b;
        ALUControl = 3'b111;
    endtask

    task automatic wait_result(input string tag);
        int   lat;
        exp_t e;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd8);
        check({tag, " scoreboard nonempty"}, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            check({tag, " ALUResult"}, ALUResult, e.res);
            check({tag, " Zero"}, 32'(Zero), 32'(e.zero));
            check({tag, " Illegal"}, 32'(Illegal), 32'(e.ill));
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid after hs"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after hs"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        wait_result(tag);
        handshake(tag);
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " ALUResult"}, ALUResult, 32'd0);
        check({tag, " Zero"}, 32'(Zero), 32'd0);
        check({tag, " Illegal"}, 32'(Illegal), 32'd0);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ALUControl = 3'b000;
        SrcA       = 32'd0;
        SrcB       = 32'd0;
        repeat (2) @(negedge clk);
        check_idle_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add 0xF+1",       OP_ADD, 32'h0000000F, 32'h00000001);
        run_op("add wrap",        OP_ADD, 32'hFFFFFFFF, 32'h00000001);
        run_op("add carry chain", OP_ADD, 32'h0FFFFFFF, 32'h00000001);
        run_op("sub 5-5",         OP_SUB, 32'h00000005, 32'h00000005);
        run_op("sub 3-5",         OP_SUB, 32'h00000003, 32'h00000005);
        run_op("sub mixed",       OP_SUB, 32'h12345678, 32'h0FEDCBA9);
        run_op("slt min vs 1",    OP_SLT, 32'h80000000, 32'h00000001);
        run_op("slt 5 vs -1",     OP_SLT, 32'h00000005, 32'hFFFFFFFF);
        run_op("slt overflow",    OP_SLT, 32'h7FFFFFFF, 32'h80000000);
        run_op("slt -1 vs 0",     OP_SLT, 32'hFFFFFFFF, 32'h00000000);
        run_op("slt equal",       OP_SLT, 32'h00000042, 32'h00000042);
        run_op("and",             OP_AND, 32'hF0F0F0F0, 32'hFF00FF00);
        run_op("or",              OP_OR,  32'hF0F0F0F0, 32'hFF00FF00);
        run_op("illegal 100",     3'b100, 32'h12345678, 32'h9ABCDEF0);
        run_op("illegal 111",     3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // Backpressure: DONE held with in_valid/SrcA wiggling
        issue(OP_ADD, 32'd1, 32'd2);
        wait_result("bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            SrcA     = $urandom;
            @(negedge clk);
            check("bp held out_valid", 32'(out_valid), 32'd1);
            check("bp held in_ready", 32'(in_ready), 32'd0);
            check("bp held ALUResult", ALUResult, 32'd3);
            check("bp held Zero", 32'(Zero), 32'd0);
            check("bp held Illegal", 32'(Illegal), 32'd0);
        end
        in_valid   = 1'b1;
        ALUControl = OP_OR;
        SrcA       = 32'h0F0F0000;
        SrcB       = 32'h000000F0;
        q.push_back(model(OP_OR, 32'h0F0F0000, 32'h000000F0));
        out_ready  = 1'b1;
        @(negedge clk);
        out_ready  = 1'b0;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("bp next accepted", 32'(in_ready), 32'd0);
        in_valid   = 1'b0;
        SrcA       = 32'hDEADBEEF;
        SrcB       = 32'hDEADBEEF;
        wait_result("bp next");
        handshake("bp next");

        // Reset in the middle of RUN aborts the operation
        check("abort in_ready", 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        ALUControl = OP_ADD;
        SrcA       = 32'd7;
        SrcB       = 32'd8;
        @(negedge clk);
        in_valid   = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_reset("abort async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort no out_valid", 32'(out_valid), 32'd0);
        end
        check_idle_reset("abort idle");
        run_op("add 2+2 after reset", OP_ADD, 32'd2, 32'd2);

        check("scoreboard drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
